// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite capture path.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } sprite_state_t;

    localparam int SPRITE_DIM = 32;
    localparam int DEF_TH1    = 15;
    localparam int DEF_TH2    = 30;
    localparam int DEF_TH3    = 45;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

endpackage

// File: rtl/sprite_luma_quant.sv
// Combinational 12-bit RGB to 2-bit colour index via a cheap luma estimate.
module sprite_luma_quant
    import sprite_pkg::*;
#(
    parameter int TH1 = DEF_TH1,
    parameter int TH2 = DEF_TH2,
    parameter int TH3 = DEF_TH3
) (
    input  rgb12_t     i_rgb,
    output logic [1:0] o_idx
);

    logic [5:0] w_luma;

    // Y = R + 2G + B, at most 60, so 6 bits never overflow.
    assign w_luma = {2'b00, i_rgb.r} + {1'b0, i_rgb.g, 1'b0} + {2'b00, i_rgb.b};

    always_comb begin
        o_idx = 2'd0;
        if (w_luma >= 6'(TH3)) begin
            o_idx = 2'd3;
        end else if (w_luma >= 6'(TH2)) begin
            o_idx = 2'd2;
        end else if (w_luma >= 6'(TH1)) begin
            o_idx = 2'd1;
        end
    end

endmodule

// File: rtl/sprite_capture_writer.sv
// Waits for a frame after start, then writes a quantised 32x32 window of the pixel
// stream into the sprite RAM write port.
module sprite_capture_writer
    import sprite_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DIM_BITS   = 5,
    parameter int DATA_WIDTH = 2,
    parameter int COORD_W    = 11,
    parameter int TH1        = DEF_TH1,
    parameter int TH2        = DEF_TH2,
    parameter int TH3        = DEF_TH3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [COORD_W-1:0]    origin_x,
    input  logic [COORD_W-1:0]    origin_y,
    input  logic                  sof,
    input  logic                  eof,
    input  logic                  pix_valid,
    input  logic [COORD_W-1:0]    pix_x,
    input  logic [COORD_W-1:0]    pix_y,
    input  logic [11:0]           pix_rgb,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr_w,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   wr_count
);

    localparam logic [ADDR_WIDTH:0] MAX_COUNT = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
    localparam logic [COORD_W:0]    DIM_EXT   = (COORD_W+1)'(SPRITE_DIM);

    sprite_state_t         r_state;
    logic [COORD_W-1:0]    r_ox;
    logic [COORD_W-1:0]    r_oy;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH:0]   r_count;

    logic [1:0]            w_idx;
    logic [COORD_W:0]      w_x_ext;
    logic [COORD_W:0]      w_y_ext;
    logic [COORD_W:0]      w_ox_ext;
    logic [COORD_W:0]      w_oy_ext;
    logic                  w_in_win;
    logic [COORD_W-1:0]    w_dx;
    logic [COORD_W-1:0]    w_dy;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_capturing;
    logic                  w_accept;

    sprite_luma_quant #(
        .TH1(TH1),
        .TH2(TH2),
        .TH3(TH3)
    ) u_quant (
        .i_rgb(rgb12_t'(pix_rgb)),
        .o_idx(w_idx)
    );

    // One extra bit so origin+32 near the coordinate limit cannot wrap.
    assign w_x_ext  = {1'b0, pix_x};
    assign w_y_ext  = {1'b0, pix_y};
    assign w_ox_ext = {1'b0, r_ox};
    assign w_oy_ext = {1'b0, r_oy};
    assign w_in_win = (w_x_ext >= w_ox_ext) && (w_x_ext < w_ox_ext + DIM_EXT) &&
                      (w_y_ext >= w_oy_ext) && (w_y_ext < w_oy_ext + DIM_EXT);

    assign w_dx   = pix_x - r_ox;
    assign w_dy   = pix_y - r_oy;
    assign w_addr = {w_dy[DIM_BITS-1:0], w_dx[DIM_BITS-1:0]};

    // The sof pixel itself belongs to the capture.
    assign w_capturing = (r_state == CAPTURE) || ((r_state == ARM) && sof);
    assign w_accept    = pix_valid && !abort && w_capturing && w_in_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ox    <= '0;
            r_oy    <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_we   <= w_accept;
            r_done <= 1'b0;
            if (w_accept) begin
                r_addr <= w_addr;
                r_din  <= DATA_WIDTH'(w_idx);
                if (r_count != MAX_COUNT) begin
                    r_count <= r_count + 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= ARM;
                        r_ox    <= origin_x;
                        r_oy    <= origin_y;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ARM: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (sof && eof) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (sof) begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (eof) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign we       = r_we;
    assign addr_w   = r_addr;
    assign din      = r_din;
    assign busy     = r_busy;
    assign done     = r_done;
    assign wr_count = r_count;

endmodule

// File: tb/tb_sprite_capture_writer.sv
// Directed bench for sprite_capture_writer with a cycle-level reference model.
module tb_sprite_capture_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [10:0] origin_x = '0;
    logic [10:0] origin_y = '0;
    logic        sof = 1'b0;
    logic        eof = 1'b0;
    logic        pix_valid = 1'b0;
    logic [10:0] pix_x = '0;
    logic [10:0] pix_y = '0;
    logic [11:0] pix_rgb = '0;
    logic        we;
    logic [9:0]  addr_w;
    logic [1:0]  din;
    logic        busy;
    logic        done;
    logic [10:0] wr_count;

    sprite_capture_writer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .origin_x(origin_x), .origin_y(origin_y), .sof(sof), .eof(eof),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .we(we), .addr_w(addr_w), .din(din), .busy(busy), .done(done),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int wr_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 waiting for frame, 2 capturing, 3 completion cycle
    int m_phase, m_ox, m_oy;
    int e_we, e_addr, e_din, e_busy, e_done, e_cnt;

    function automatic int quant(input logic [11:0] c);
        int y;
        y = int'(c[11:8]) + 2 * int'(c[7:4]) + int'(c[3:0]);
        if (y >= 45) return 3;
        if (y >= 30) return 2;
        if (y >= 15) return 1;
        return 0;
    endfunction

    function automatic bit in_window(input int x, input int y, input int ox, input int oy);
        return (x >= ox) && (x < ox + 32) && (y >= oy) && (y < oy + 32);
    endfunction

    function automatic bit takes_pixel(input int ph, input bit v, input bit ab, input bit s,
                                       input int x, input int y, input int ox, input int oy);
        return v && !ab && (ph == 2 || (ph == 1 && s)) && in_window(x, y, ox, oy);
    endfunction

    function automatic int next_phase(input int ph, input bit st, input bit ab, input bit s, input bit e);
        case (ph)
            0: return st ? 1 : 0;
            1: return ab ? 0 : (s && e) ? 3 : s ? 2 : 1;
            2: return ab ? 0 : e ? 3 : 2;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_ox <= 0; m_oy <= 0;
            e_we <= 0; e_addr <= 0; e_din <= 0; e_busy <= 0; e_done <= 0; e_cnt <= 0;
        end else begin
            if (takes_pixel(m_phase, pix_valid, abort, sof, int'(pix_x), int'(pix_y), m_ox, m_oy)) begin
                e_we   <= 1;
                e_addr <= ((int'(pix_y) - m_oy) % 32) * 32 + ((int'(pix_x) - m_ox) % 32);
                e_din  <= quant(pix_rgb);
                e_cnt  <= (e_cnt < 1024) ? e_cnt + 1 : 1024;
            end else begin
                e_we <= 0;
            end
            if (m_phase == 0 && start) begin
                m_ox  <= int'(origin_x);
                m_oy  <= int'(origin_y);
                e_cnt <= 0;
            end
            m_phase <= next_phase(m_phase, start, abort, sof, eof);
            e_busy  <= (next_phase(m_phase, start, abort, sof, eof) inside {1, 2}) ? 1 : 0;
            e_done  <= (next_phase(m_phase, start, abort, sof, eof) == 3) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("we", int'(we), e_we);
            chk("busy", int'(busy), e_busy);
            chk("done", int'(done), e_done);
            chk("wr_count", int'(wr_count), e_cnt);
            if (e_we != 0) begin
                chk("addr_w", int'(addr_w), e_addr);
                chk("din", int'(din), e_din);
            end
            if (we) wr_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pix_valid = 0; sof = 0; eof = 0;
        repeat (n) cyc();
    endtask

    task automatic do_start(input int x, input int y);
        pix_valid = 0; sof = 0; eof = 0;
        start = 1; origin_x = 11'(x); origin_y = 11'(y);
        cyc();
        start = 0;
    endtask

    task automatic px(input int x, input int y, input logic [11:0] c, input bit s, input bit e);
        pix_valid = 1; pix_x = 11'(x); pix_y = 11'(y); pix_rgb = c; sof = s; eof = e;
        cyc();
    endtask

    initial begin
        // reset state
        idle(3);
        chk("rst_we", int'(we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(wr_count), 0);
        @(negedge clk);
        rst_n = 1;
        idle(2);

        // 1: full window, white
        wr_seen = 0;
        do_start(100, 50);
        chk("t1_busy", int'(busy), 1);
        px(0, 0, 12'hFFF, 1, 0);
        for (int y = 48; y < 84; y++)
            for (int x = 96; x < 136; x++)
                px(x, y, 12'hFFF, 0, 0);
        px(639, 479, 12'hFFF, 0, 1);
        chk("t1_done", int'(done), 1);
        chk("t1_count", int'(wr_count), 1024);
        chk("t1_writes", wr_seen, 1024);
        chk("t1_last_addr", int'(addr_w), 1023);
        chk("t1_din", int'(din), 3);
        idle(2);

        // 2: corner pixel and just-outside pixels
        do_start(100, 50);
        px(0, 0, 12'h000, 1, 0);
        px(131, 81, 12'h0F0, 0, 0);
        chk("t2_we", int'(we), 1);
        chk("t2_addr", int'(addr_w), 10'h3FF);
        chk("t2_din", int'(din), 2);
        px(132, 81, 12'hFFF, 0, 0);
        chk("t2_right_out", int'(we), 0);
        px(99, 50, 12'hFFF, 0, 0);
        chk("t2_left_out", int'(we), 0);
        px(639, 479, 12'h000, 0, 1);
        chk("t2_done", int'(done), 1);
        chk("t2_count", int'(wr_count), 1);
        idle(2);

        // 3: window hanging off the bottom-right corner
        do_start(630, 470);
        px(0, 0, 12'h000, 1, 0);
        for (int y = 466; y < 480; y++)
            for (int x = 626; x < 640; x++)
                px(x, y, 12'(x * 37 + y * 11), 0, (x == 639 && y == 479));
        chk("t3_we", int'(we), 1);
        chk("t3_addr", int'(addr_w), 10'h129);
        chk("t3_done", int'(done), 1);
        chk("t3_count", int'(wr_count), 100);
        idle(2);

        // 4: pixels before sof ignored, abort mid-frame
        do_start(100, 50);
        px(100, 50, 12'hFFF, 0, 0);
        chk("t4_arm_ignore", int'(we), 0);
        px(101, 50, 12'hFFF, 0, 0);
        chk("t4_arm_count", int'(wr_count), 0);
        px(0, 0, 12'h000, 1, 0);
        for (int x = 100; x < 106; x++)
            px(x, 50, 12'(x * 291), 0, 0);
        abort = 1;
        px(106, 50, 12'hFFF, 0, 0);
        abort = 0;
        chk("t4_abort_we", int'(we), 0);
        chk("t4_abort_busy", int'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("t4_no_done", int'(done), 0);
        end
        chk("t4_count", int'(wr_count), 6);
        px(120, 60, 12'hFFF, 0, 1);
        chk("t4_idle_we", int'(we), 0);
        idle(2);

        // 5: restart while busy ignored; sof+eof together in ARM
        do_start(100, 50);
        idle(1);
        do_start(0, 0);
        chk("t5_busy", int'(busy), 1);
        px(100, 50, 12'h555, 1, 1);
        chk("t5_we", int'(we), 1);
        chk("t5_addr", int'(addr_w), 0);
        chk("t5_din", int'(din), 1);
        chk("t5_done", int'(done), 1);
        chk("t5_count", int'(wr_count), 1);
        idle(2);

        // 6: asynchronous reset mid-capture
        do_start(0, 0);
        px(0, 0, 12'hFFF, 1, 0);
        px(1, 0, 12'hFFF, 0, 0);
        chk("t6_pre_we", int'(we), 1);
        chk("t6_pre_busy", int'(busy), 1);
        rst_n = 0;
        #1;
        chk("t6_we", int'(we), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_count", int'(wr_count), 0);
        idle(2);
        @(negedge clk);
        rst_n = 1;
        idle(2);
        chk("t6_after_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
